// File: rtl/chnl_pkg.sv
// ============================================================================
// Module      : chnl_pkg
// Description : Shared types and helpers for the RIFFA-style TX channel path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package chnl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } tx_state_t;

    localparam int CHNL_OFF_W = 31;

    // Transaction length expressed in 32-bit channel words.
    function automatic logic [31:0] tx_len(input int width, input int burst);
        return 32'(burst * width / 32);
    endfunction

endpackage

`default_nettype wire

// File: rtl/chnl_tx_burst.sv
// ============================================================================
// Module      : chnl_tx_burst
// Description : Drains a burst-mode FIFO into a PCIe TX channel, BURST words
//               per transaction, paced by the host read enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chnl_tx_burst
    import chnl_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int BURST = 16
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic                  en_i,
    input  logic                  in_val_i,
    input  logic [WIDTH-1:0]      in_data_i,
    output logic                  in_rdy_o,
    output logic                  chnl_tx_o,
    output logic                  chnl_tx_last_o,
    output logic [31:0]           chnl_tx_len_o,
    output logic [CHNL_OFF_W-1:0] chnl_tx_off_o,
    input  logic                  chnl_tx_ack_i,
    output logic [WIDTH-1:0]      chnl_tx_data_o,
    output logic                  chnl_tx_data_valid_o,
    input  logic                  chnl_tx_data_ren_i,
    output logic [31:0]           burst_cnt_o
);

    localparam int              BEAT_W    = $clog2(BURST + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);

    if (!(WIDTH == 32 || WIDTH == 64 || WIDTH == 128)) begin : g_bad_width
        $error("chnl_tx_burst: WIDTH must be 32, 64 or 128");
    end

    if (BURST < 1) begin : g_bad_burst
        $error("chnl_tx_burst: BURST must be at least 1");
    end

    tx_state_t         state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [31:0]       burst_cnt_q, burst_cnt_d;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Once committed in DATA, valid stays high even as the FIFO's burst
    // indication falls: the FIFO still holds the remainder of the burst.
    always_comb begin
        state_d              = state_q;
        beat_d               = beat_q;
        burst_cnt_d          = burst_cnt_q;
        chnl_tx_o            = 1'b0;
        chnl_tx_data_valid_o = 1'b0;
        in_rdy_o             = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en_i && in_val_i) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                chnl_tx_o = 1'b1;
                if (chnl_tx_ack_i) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                chnl_tx_o            = 1'b1;
                chnl_tx_data_valid_o = 1'b1;
                in_rdy_o             = chnl_tx_data_ren_i;
                if (chnl_tx_data_ren_i) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d      = '0;
                        burst_cnt_d = burst_cnt_q + 32'd1;
                        state_d     = GAP;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign chnl_tx_last_o = 1'b1;
    assign chnl_tx_len_o  = tx_len(WIDTH, BURST);
    assign chnl_tx_off_o  = '0;
    assign chnl_tx_data_o = in_data_i;
    assign burst_cnt_o    = burst_cnt_q;

endmodule

`default_nettype wire
